// File: rtl/mips_cpu_pkg.sv
// Shared MIPS CPU definitions: fetch FSM states, fixed addresses
// and the byte-reversal helper used by the instruction fetch unit.
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    F_IDLE  = 3'd0,
    F_REQ   = 3'd1,
    F_HOLD  = 3'd2,
    F_HALT  = 3'd3,
    F_FAULT = 3'd4
  } fetch_state_t;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDR    = 32'h0000_0000;

  function automatic logic [31:0] byteswap32(
    input logic [31:0] w
  );
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/mips_cpu_ifetch.sv
// Instruction fetch: reads the word at pc_in over a waitrequest bus,
// holds it in instr for decode, pulses pc_advance on each accept.
// Ports: clk, rst (async active-low), pc_in/pc_advance to the PC
// unit, mem_* bus master, instr/instr_valid/instr_ready to decode,
// active (low once halted), fault (sticky misalign), fetch_count.
// Option: MIPS_CPU_IFETCH_BYTESWAP_EN byte-reverses fetched words.
module mips_cpu_ifetch
  import mips_cpu_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pc_in,
  output logic               pc_advance,
  output logic [31:0]        mem_address,
  output logic               mem_read,
  input  logic               mem_waitrequest,
  input  logic [31:0]        mem_readdata,
  output logic [31:0]        instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               active,
  output logic               fault,
  output logic [COUNT_W-1:0] fetch_count
);

  fetch_state_t state, state_n;

  logic        pc_halt;
  logic        pc_misal;
  logic        rd_ok;
  logic        capture;
  logic        accept;
  logic [31:0] fetch_word;

  assign pc_halt  = (pc_in == HALT_ADDR);
  assign pc_misal = (pc_in[1:0] != 2'b00);
  assign rd_ok    = !pc_halt && !pc_misal;

`ifdef MIPS_CPU_IFETCH_BYTESWAP_EN
  assign fetch_word = byteswap32(mem_readdata);
`else
  assign fetch_word = mem_readdata;
`endif

  // Derived from state so reset drops mem_read with no edge.
  assign mem_address = pc_in;
  assign mem_read    = (state == F_REQ) && rd_ok;
  assign instr_valid = (state == F_HOLD);
  assign pc_advance  = (state == F_HOLD) && instr_ready;
  assign active      = (state != F_HALT);
  assign fault       = (state == F_FAULT);

  assign capture = mem_read && !mem_waitrequest;
  assign accept  = pc_advance;

  always_comb begin
    state_n = state;
    case (state)
      F_IDLE: state_n = F_REQ;
      F_REQ: begin
        if (pc_halt)
          state_n = F_HALT;
        else if (pc_misal)
          state_n = F_FAULT;
        else if (!mem_waitrequest)
          state_n = F_HOLD;
      end
      F_HOLD: begin
        if (instr_ready)
          state_n = F_REQ;
      end
      F_HALT:  state_n = F_HALT;
      F_FAULT: state_n = F_FAULT;
      default: state_n = F_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= F_IDLE;
      instr       <= '0;
      fetch_count <= '0;
    end else begin
      state <= state_n;
      if (capture)
        instr <= fetch_word;
      if (accept)
        fetch_count <= fetch_count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_cpu_ifetch.sv
// Bench for mips_cpu_ifetch: directed fetches with a scoreboard
// monitor checking captured addresses and accepted instructions.
module tb_mips_cpu_ifetch;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   pc_in = '0;
  logic          pc_advance;
  logic [31:0]   mem_address;
  logic          mem_read;
  logic          mem_waitrequest = 1'b1;
  logic [31:0]   mem_readdata = '0;
  logic [31:0]   instr;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic          active;
  logic          fault;
  logic [CW-1:0] fetch_count;

  mips_cpu_ifetch #(.COUNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_in           (pc_in),
    .pc_advance      (pc_advance),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_waitrequest (mem_waitrequest),
    .mem_readdata    (mem_readdata),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .active          (active),
    .fault           (fault),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rd_cycles = 0;
  int adv_cnt = 0;
  int exp_cnt = 0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_instr[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] d);
`ifdef MIPS_CPU_IFETCH_BYTESWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mem_read)
      rd_cycles++;
    if (pc_advance)
      adv_cnt++;
    if (mem_read && !mem_waitrequest) begin
      if (exp_addr.size() == 0)
        chk("unexpected_read", mem_address, 32'hxxxx_xxxx);
      else
        chk("read_addr", mem_address, exp_addr.pop_front());
    end
    if (instr_valid && instr_ready) begin
      if (exp_instr.size() == 0)
        chk("unexpected_accept", instr, 32'hxxxx_xxxx);
      else
        chk("accept_instr", instr, exp_instr.pop_front());
      chk("accept_pc_advance", {31'd0, pc_advance}, 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_read", {31'd0, mem_read}, 32'd0);
    chk("rst_adv", {31'd0, pc_advance}, 32'd0);
    chk("rst_active", {31'd0, active}, 32'd1);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_count", {30'd0, fetch_count}, 32'd0);
    exp_cnt = 0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Called at posedge+1; leaves DUT in REQ after the accept edge.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] d,
                       input int nwait, input int nstall);
    int w;
    int cyc;
    int rd0;
    int adv0;
    bit addr_ok;
    w = 0;
    cyc = 0;
    addr_ok = 1'b1;
    rd0 = rd_cycles;
    adv0 = adv_cnt;
    pc_in = pc;
    mem_readdata = d;
    instr_ready = 1'b0;
    mem_waitrequest = (nwait > 0);
    exp_addr.push_back(pc);
    exp_instr.push_back(model_word(d));
    #1;
    while (!instr_valid && cyc < 50) begin
      if (mem_read) begin
        w++;
        if (mem_address !== pc)
          addr_ok = 1'b0;
        if (w > nwait)
          mem_waitrequest = 1'b0;
      end
      tick();
      cyc++;
    end
    mem_waitrequest = 1'b1;
    chk("valid_timeout", {31'd0, instr_valid}, 32'd1);
    chk("addr_stable", {31'd0, addr_ok}, 32'd1);
    chk("read_cycles", rd_cycles - rd0, nwait + 1);
    chk("hold_instr", instr, model_word(d));
    repeat (nstall) tick();
    if (nstall > 0) begin
      chk("stall_instr", instr, model_word(d));
      chk("stall_adv", adv_cnt - adv0, 32'd0);
      chk("stall_no_read", rd_cycles - rd0, nwait + 1);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % 4;
    chk("adv_once", adv_cnt - adv0, 32'd1);
    chk("fetch_count", {30'd0, fetch_count}, exp_cnt);
    chk("valid_drop", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0;
    int adv0;
    do_reset();
    fetch(32'hBFC0_0000, 32'h2402_0005, 0, 0);
    fetch(32'hBFC0_0004, 32'h8C43_0010, 3, 0);
    fetch(32'hBFC0_0008, 32'hAC43_0014, 0, 5);
    fetch(32'hBFC0_000C, 32'h0043_1020, 1, 0);
    fetch(32'hBFC0_0010, 32'h1000_FFFF, 0, 0);
    chk("count_wrap", {30'd0, fetch_count}, 32'd1);

    // Halt: pc_in = 0 while in REQ.
    pc_in = 32'h0;
    rd0 = rd_cycles;
    adv0 = adv_cnt;
    instr_ready = 1'b1;
    tick();
    chk("halt_active", {31'd0, active}, 32'd0);
    chk("halt_read", {31'd0, mem_read}, 32'd0);
    repeat (3) tick();
    pc_in = 32'hBFC0_0020;
    tick();
    chk("halt_sticky", {31'd0, active}, 32'd0);
    chk("halt_valid", {31'd0, instr_valid}, 32'd0);
    chk("halt_no_read", rd_cycles - rd0, 32'd0);
    chk("halt_no_adv", adv_cnt - adv0, 32'd0);
    instr_ready = 1'b0;
    chk("sb_empty_a", exp_addr.size() + exp_instr.size(), 32'd0);

    // Misaligned PC.
    pc_in = 32'hBFC0_0002;
    do_reset();
    rd0 = rd_cycles;
    repeat (4) tick();
    chk("fault_set", {31'd0, fault}, 32'd1);
    chk("fault_no_read", rd_cycles - rd0, 32'd0);
    chk("fault_valid", {31'd0, instr_valid}, 32'd0);
    chk("fault_active", {31'd0, active}, 32'd1);
    rst = 1'b0;
    #1;
    chk("fault_clear", {31'd0, fault}, 32'd0);

    // Reset during a stalled read.
    pc_in = 32'hBFC0_0100;
    mem_waitrequest = 1'b1;
    do_reset();
    repeat (3) tick();
    chk("wait_read", {31'd0, mem_read}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_read", {31'd0, mem_read}, 32'd0);
    chk("abort_valid", {31'd0, instr_valid}, 32'd0);
    chk("abort_count", {30'd0, fetch_count}, 32'd0);
    chk("sb_empty_b", exp_addr.size() + exp_instr.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
